// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the iCEBreaker UART slice: the transmitter state
// encoding, the frame payload width and the clocks-per-bit helper used to
// size the baud counter.
// ---------------------------------------------------------------------------
package uart_pkg;

    // Transmitter states, in the order the line passes through them
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int DATA_BITS = 8;

    // Core cycles spent on each serial bit (truncating division)
    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// 8N1 UART transmitter: one start bit (0), eight data bits LSB first, one
// stop bit (1). Every level is held for CLKS_PER_BIT core cycles.
//
// Ports:
//   clk      core clock
//   rst      synchronous active-high reset
//   valid_i  one-cycle request; only honoured while idle
//   data_i   byte captured on an accepted request
//   tx_o     registered serial line, idles high
//   busy_o   high while a frame is in flight
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_i,
    input  logic [DATA_BITS-1:0] data_i,
    output logic                 tx_o,
    output logic                 busy_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    tx_state_e            r_state;
    logic [CNT_W-1:0]     r_baudCnt;
    logic [IDX_W-1:0]     r_bitIdx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 w_bitDone;

    // The current serial level has been held for a full bit period
    assign w_bitDone = (r_baudCnt == LAST_CNT);

    // Frame sequencer. The line level is registered and always loaded with
    // the level of the state being entered, so the output changes exactly on
    // the bit boundary and never glitches. Requests arriving while a frame
    // is in flight are simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitIdx  <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (valid_i) begin
                        r_shift   <= data_i;
                        r_bitIdx  <= '0;
                        r_baudCnt <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (w_bitDone) begin
                        r_baudCnt <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= DATA;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bitDone) begin
                        r_baudCnt <= '0;
                        if (r_bitIdx == LAST_IDX) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bitIdx <= r_bitIdx + 1'b1;
                            r_shift  <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx     <= r_shift[1];
                        end
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bitDone) begin
                        r_baudCnt <= '0;
                        r_state   <= IDLE;
                    end else begin
                        r_baudCnt <= r_baudCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o   = r_tx;
    assign busy_o = (r_state != IDLE);

endmodule

// File: rtl/icebreaker_uart_top.sv
// ---------------------------------------------------------------------------
// icebreaker_uart_top
// iCEBreaker top level: a press of BTN1 sends the byte on data_i as one 8N1
// frame on the active-low green LED.
//
// Ports:
//   CLK     12 MHz board clock
//   BTN_N   reset button, active-low
//   BTN1    send button, active-high, asynchronous
//   data_i  byte to send, sampled when the press is accepted
//   LEDG_N  serial line (idle high = LED off)
//
// Build option: define ICE40_PLL_EN to run the core from an SB_PLL40_PAD at
// 50 MHz; otherwise the core runs directly from CLK at 12 MHz.
// ---------------------------------------------------------------------------
module icebreaker_uart_top
    import uart_pkg::*;
#(
`ifdef ICE40_PLL_EN
    parameter int CLK_FREQ_HZ = 50_000_000,
`else
    parameter int CLK_FREQ_HZ = 12_000_000,
`endif
    parameter int BAUD_RATE   = 115200
) (
    input  logic       CLK,
    input  logic       BTN_N,
    input  logic       BTN1,
    input  logic [7:0] data_i,
    output logic       LEDG_N
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);

    logic       w_coreClk;
    logic       w_pllLock;
    logic       w_rst;
    logic       w_txBusy;
    logic [1:0] r_rstSync;
    logic [1:0] r_btnSync;
    logic       r_btnPrev;
    logic       r_sendPulse;

`ifdef ICE40_PLL_EN
    // 12 MHz -> 50 MHz: 12 * (DIVF+1) / 2^DIVQ = 12 * 67 / 16
    SB_PLL40_PAD #(
        .FEEDBACK_PATH("SIMPLE"),
        .DIVR(4'b0000),
        .DIVF(7'b1000010),
        .DIVQ(3'b100),
        .FILTER_RANGE(3'b001)
    ) pll (
        .PACKAGEPIN(CLK),
        .PLLOUTCORE(),
        .PLLOUTGLOBAL(w_coreClk),
        .RESETB(1'b1),
        .BYPASS(1'b0),
        .LOCK(w_pllLock)
    );
`else
    assign w_coreClk = CLK;
    assign w_pllLock = 1'b1;
`endif

    // Reset generator: the button (and an unlocked PLL) is pulled through
    // two flops so the core sees a clean synchronous reset that lingers two
    // cycles after the button is released. These flops are never reset.
    always_ff @(posedge w_coreClk) begin
        r_rstSync <= {r_rstSync[0], ~BTN_N | ~w_pllLock};
    end

    assign w_rst = r_rstSync[1];

    // Send button: two-flop synchroniser, then a registered rising-edge
    // detector so exactly one single-cycle pulse results per press, however
    // long the button is held.
    always_ff @(posedge w_coreClk) begin
        if (w_rst) begin
            r_btnSync   <= '0;
            r_btnPrev   <= 1'b0;
            r_sendPulse <= 1'b0;
        end else begin
            r_btnSync   <= {r_btnSync[0], BTN1};
            r_btnPrev   <= r_btnSync[1];
            r_sendPulse <= r_btnSync[1] & ~r_btnPrev;
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (w_coreClk),
        .rst    (w_rst),
        .valid_i(r_sendPulse & ~w_txBusy),
        .data_i (data_i),
        .tx_o   (LEDG_N),
        .busy_o (w_txBusy)
    );

endmodule

// File: tb/tb_icebreaker_uart_top.sv
// ---------------------------------------------------------------------------
// tb_icebreaker_uart_top
// Directed bench for the default (no PLL) build: 12 MHz core, 115200 baud,
// so every serial level lasts 104 core cycles.
// ---------------------------------------------------------------------------
module tb_icebreaker_uart_top;

    localparam int CPB = 104;

    logic       CLK = 1'b0;
    logic       BTN_N;
    logic       BTN1;
    logic [7:0] data_i;
    logic       LEDG_N;

    int checks = 0;
    int errors = 0;

    icebreaker_uart_top dut (
        .CLK   (CLK),
        .BTN_N (BTN_N),
        .BTN1  (BTN1),
        .data_i(data_i),
        .LEDG_N(LEDG_N)
    );

    always #5 CLK = ~CLK;

    // Advance one core cycle, landing on the falling edge for sampling
    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Entered on the first cycle of the start bit. Checks the first, middle
    // and last cycle of every level, optionally releasing BTN1 or pressing it
    // again (with new data) part way through, and finishes on the first cycle
    // after the stop bit, where the line must be idle.
    task automatic checkFrame(input logic [7:0] data, input string name,
                              input int releaseAt, input int repressAt,
                              input logic [7:0] repressData);
        logic [9:0] levels;
        levels = {1'b1, data, 1'b0};
        for (int c = 0; c < 10 * CPB; c++) begin
            if (c == releaseAt) BTN1 = 1'b0;
            if (c == repressAt) begin
                data_i = repressData;
                BTN1   = 1'b1;
            end
            if (repressAt >= 0 && c == repressAt + 20) BTN1 = 1'b0;
            if ((c % CPB) == 0 || (c % CPB) == CPB / 2 || (c % CPB) == CPB - 1) begin
                checks++;
                if (LEDG_N !== levels[c / CPB]) begin
                    errors++;
                    $display("[TB] FAIL %s level %0d cycle %0d: LEDG_N=%b expected %b",
                             name, c / CPB, c, LEDG_N, levels[c / CPB]);
                end
            end
            tick();
        end
        checks++;
        if (LEDG_N !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_idle: LEDG_N=%b expected 1", name, LEDG_N);
        end
    endtask

    // Line must stay high for n cycles, sampled every step cycles
    task automatic checkIdle(input string name, input int n, input int step);
        for (int i = 0; i < n; i++) begin
            if ((i % step) == 0) begin
                checks++;
                if (LEDG_N !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL %s cycle %0d: LEDG_N=%b expected 1", name, i, LEDG_N);
                end
            end
            tick();
        end
    endtask

    // Press BTN1 and confirm the start bit appears on the 4th edge
    task automatic pressAndStart(input logic [7:0] data, input string name);
        data_i = data;
        BTN1   = 1'b1;
        repeat (3) tick();
        checks++;
        if (LEDG_N !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_latency: LEDG_N=%b expected 1 before 4th edge", name, LEDG_N);
        end
        tick();
    endtask

    task automatic test_reset();
        BTN_N  = 1'b0;
        BTN1   = 1'b0;
        data_i = 8'h00;
        @(negedge CLK);
        repeat (5) tick();
        checks++;
        if (LEDG_N !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_hold: LEDG_N=%b expected 1", LEDG_N);
        end
        BTN_N = 1'b1;
        checkIdle("reset_release", 8, 1);
    endtask

    // Reset lingers two cycles after release, so a press made at the same
    // moment reaches the line two edges later than usual (6th edge)
    task automatic test_reset_release_press();
        BTN_N = 1'b0;
        repeat (4) tick();
        BTN_N  = 1'b1;
        BTN1   = 1'b1;
        data_i = 8'h81;
        repeat (5) tick();
        checks++;
        if (LEDG_N !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rel_press_latency: LEDG_N=%b expected 1 after 5 edges", LEDG_N);
        end
        tick();
        checkFrame(8'h81, "rel_press", 50, -1, 8'h00);
    endtask

    task automatic test_send_55();
        pressAndStart(8'h55, "send55");
        checkFrame(8'h55, "send55", 50, -1, 8'h00);
    endtask

    task automatic test_hold();
        pressAndStart(8'hA3, "hold");
        checkFrame(8'hA3, "hold", -1, -1, 8'h00);
        checkIdle("hold_after", 20 * CPB, CPB / 2);
        BTN1 = 1'b0;
        checkIdle("hold_release", 8, 1);
    endtask

    task automatic test_busy();
        pressAndStart(8'h0F, "busy");
        checkFrame(8'h0F, "busy", 50, 5 * CPB, 8'hF0);
        checkIdle("busy_after", 2 * CPB, CPB / 4);
    endtask

    task automatic test_reset_mid();
        pressAndStart(8'h00, "rstmid");
        for (int c = 0; c < 4 * CPB + CPB / 2; c++) begin
            if (c == 50) BTN1 = 1'b0;
            tick();
        end
        checks++;
        if (LEDG_N !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_bit3: LEDG_N=%b expected 0", LEDG_N);
        end
        BTN_N = 1'b0;
        tick();
        tick();
        checks++;
        if (LEDG_N !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rstmid_sync: LEDG_N=%b expected 0 while reset synchronises", LEDG_N);
        end
        tick();
        checks++;
        if (LEDG_N !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rstmid_abort: LEDG_N=%b expected 1", LEDG_N);
        end
        repeat (5) tick();
        BTN_N = 1'b1;
        checkIdle("rstmid_idle", 3 * CPB, CPB / 4);
        pressAndStart(8'hFF, "rstmid_next");
        checkFrame(8'hFF, "rstmid_next", 50, -1, 8'h00);
    endtask

    // Second press timed so its pulse lands on the first idle cycle after
    // the stop bit: the next start bit must follow one cycle later
    task automatic test_back_to_back();
        pressAndStart(8'h00, "b2b_a");
        checkFrame(8'h00, "b2b_a", 50, 10 * CPB - 3, 8'hFF);
        tick();
        checkFrame(8'hFF, "b2b_b", 20, -1, 8'h00);
        checkIdle("b2b_after", CPB, CPB / 4);
    endtask

    initial begin
        $display("[TB] starting icebreaker_uart_top bench");
        test_reset();
        test_reset_release_press();
        test_send_55();
        test_hold();
        test_busy();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
